// File: rtl/hit_resolver.sv
// Resolves fighting-game hits between two players and tracks health, invulnerability and KO.
// Latency: one tick from sampled boxes/states to registered health and hit pulses.
// Backpressure: none; every tick is evaluated.
module hit_resolver #(
  parameter logic [3:0] ACTIVE_STATE = 4'd4,
  parameter logic [6:0] MAX_HEALTH   = 7'd100,
  parameter logic [6:0] DAMAGE       = 7'd10,
  parameter logic [5:0] INVULN_TICKS = 6'd30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] p1_state,
  input  logic [3:0] p2_state,
  input  logic [9:0] p1_hit_x1,
  input  logic [9:0] p1_hit_x2,
  input  logic [9:0] p1_hit_y1,
  input  logic [9:0] p1_hit_y2,
  input  logic [9:0] p2_hit_x1,
  input  logic [9:0] p2_hit_x2,
  input  logic [9:0] p2_hit_y1,
  input  logic [9:0] p2_hit_y2,
  input  logic [9:0] p1_hurt_x1,
  input  logic [9:0] p1_hurt_x2,
  input  logic [9:0] p1_hurt_y1,
  input  logic [9:0] p1_hurt_y2,
  input  logic [9:0] p2_hurt_x1,
  input  logic [9:0] p2_hurt_x2,
  input  logic [9:0] p2_hurt_y1,
  input  logic [9:0] p2_hurt_y2,
  output logic [6:0] health1,
  output logic [6:0] health2,
  output logic       hit1,
  output logic       hit2,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef struct packed {
    logic [9:0] x1;
    logic [9:0] x2;
    logic [9:0] y1;
    logic [9:0] y2;
  } box_t;

  typedef enum logic {FIGHT = 1'b0, KO = 1'b1} state_t;

  // An inverted box (x1>x2 or y1>y2) is treated as absent.
  function automatic logic overlap(input box_t a, input box_t b);
    return (a.x1 <= a.x2) && (a.y1 <= a.y2) && (b.x1 <= b.x2) && (b.y1 <= b.y2) &&
           (a.x1 <= b.x2) && (b.x1 <= a.x2) && (a.y1 <= b.y2) && (b.y1 <= a.y2);
  endfunction

  box_t p1_hit_box, p2_hit_box, p1_hurt_box, p2_hurt_box;
  assign p1_hit_box  = '{p1_hit_x1,  p1_hit_x2,  p1_hit_y1,  p1_hit_y2};
  assign p2_hit_box  = '{p2_hit_x1,  p2_hit_x2,  p2_hit_y1,  p2_hit_y2};
  assign p1_hurt_box = '{p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2};
  assign p2_hurt_box = '{p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2};

  state_t     state_q, state_n;
  logic [5:0] inv1_q, inv2_q, inv1_n, inv2_n;
  logic       landed12_q, landed21_q, landed12_n, landed21_n;
  logic [6:0] health1_n, health2_n;
  logic       hit1_n, hit2_n;
  logic [1:0] winner_n;
  logic       p1_active, p2_active, strike12, strike21;

  assign p1_active = (p1_state == ACTIVE_STATE);
  assign p2_active = (p2_state == ACTIVE_STATE);
  assign strike12  = (state_q == FIGHT) && p1_active && overlap(p1_hit_box, p2_hurt_box) &&
                     !landed12_q && (inv2_q == '0);
  assign strike21  = (state_q == FIGHT) && p2_active && overlap(p2_hit_box, p1_hurt_box) &&
                     !landed21_q && (inv1_q == '0);
  assign game_over = (state_q == KO);

  always_comb begin
    state_n    = state_q;
    health1_n  = health1;
    health2_n  = health2;
    winner_n   = winner;
    hit1_n     = 1'b0;
    hit2_n     = 1'b0;
    inv1_n     = (inv1_q != '0) ? inv1_q - 6'd1 : 6'd0;
    inv2_n     = (inv2_q != '0) ? inv2_q - 6'd1 : 6'd0;
    landed12_n = p1_active && (landed12_q || strike12);
    landed21_n = p2_active && (landed21_q || strike21);
    if (state_q == FIGHT) begin
      if (strike12) begin
        health2_n = (health2 > DAMAGE) ? health2 - DAMAGE : 7'd0;
        hit2_n    = 1'b1;
        inv2_n    = INVULN_TICKS;
      end
      if (strike21) begin
        health1_n = (health1 > DAMAGE) ? health1 - DAMAGE : 7'd0;
        hit1_n    = 1'b1;
        inv1_n    = INVULN_TICKS;
      end
      // Winner bits: bit1 = player 2 won (health1 gone), bit0 = player 1 won.
      if ((health1_n == 7'd0) || (health2_n == 7'd0)) begin
        state_n  = KO;
        winner_n = {health1_n == 7'd0, health2_n == 7'd0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FIGHT;
      health1    <= MAX_HEALTH;
      health2    <= MAX_HEALTH;
      hit1       <= 1'b0;
      hit2       <= 1'b0;
      winner     <= 2'b00;
      inv1_q     <= 6'd0;
      inv2_q     <= 6'd0;
      landed12_q <= 1'b0;
      landed21_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      health1    <= health1_n;
      health2    <= health2_n;
      hit1       <= hit1_n;
      hit2       <= hit2_n;
      winner     <= winner_n;
      inv1_q     <= inv1_n;
      inv2_q     <= inv2_n;
      landed12_q <= landed12_n;
      landed21_q <= landed21_n;
    end
  end

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: single hits, invulnerability, trades, box edges, KO and reset priority.
module tb_hit_resolver;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] p1_state, p2_state;
  logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
  logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
  logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
  logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
  logic [6:0] health1, health2;
  logic       hit1, hit2, game_over;
  logic [1:0] winner;

  int n_checks = 0;
  int n_errors = 0;

  hit_resolver dut (
    .clk(clk), .rst(rst), .p1_state(p1_state), .p2_state(p2_state),
    .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2), .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
    .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2), .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
    .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2), .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
    .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2), .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
    .health1(health1), .health2(health2), .hit1(hit1), .hit2(hit2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // p1_hit overlaps p2_hurt, p2_hit overlaps p1_hurt.
  task automatic default_boxes();
    p1_hit_x1 = 10'd200; p1_hit_x2 = 10'd260; p1_hit_y1 = 10'd100; p1_hit_y2 = 10'd140;
    p2_hurt_x1 = 10'd250; p2_hurt_x2 = 10'd330; p2_hurt_y1 = 10'd80; p2_hurt_y2 = 10'd236;
    p2_hit_x1 = 10'd300; p2_hit_x2 = 10'd360; p2_hit_y1 = 10'd100; p2_hit_y2 = 10'd140;
    p1_hurt_x1 = 10'd150; p1_hurt_x2 = 10'd310; p1_hurt_y1 = 10'd80; p1_hurt_y2 = 10'd236;
  endtask

  task automatic apply_reset();
    rst = 1'b1; p1_state = 4'd0; p2_state = 4'd0;
    default_boxes();
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (health1 !== 7'd100) begin n_errors++; $display("FAIL reset_health1: got %0d expected 100", health1); end
    n_checks++; if (health2 !== 7'd100) begin n_errors++; $display("FAIL reset_health2: got %0d expected 100", health2); end
    n_checks++; if ({hit1, hit2} !== 2'b00) begin n_errors++; $display("FAIL reset_hits: got %b expected 00", {hit1, hit2}); end
    n_checks++; if (game_over !== 1'b0) begin n_errors++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
    n_checks++; if (winner !== 2'b00) begin n_errors++; $display("FAIL reset_winner: got %b expected 00", winner); end
  endtask

  task automatic test_single_hit();
    int pulses;
    apply_reset();
    p1_state = 4'd4;
    pulses = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (hit2 === 1'b1) pulses++;
      if (k == 1) begin
        n_checks++; if (hit2 !== 1'b1) begin n_errors++; $display("FAIL single_first_pulse: got %b expected 1", hit2); end
      end
    end
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL single_pulse_count: got %0d expected 1", pulses); end
    n_checks++; if (health2 !== 7'd90) begin n_errors++; $display("FAIL single_health2: got %0d expected 90", health2); end
    n_checks++; if (health1 !== 7'd100) begin n_errors++; $display("FAIL single_health1: got %0d expected 100", health1); end
    n_checks++; if (hit1 !== 1'b0) begin n_errors++; $display("FAIL single_hit1: got %b expected 0", hit1); end
    p1_state = 4'd0;
    tick();
  endtask

  task automatic test_reattack();
    apply_reset();
    p1_state = 4'd4;
    tick();
    for (int k = 1; k <= 35; k++) begin
      p1_state = (k == 10 || k == 35) ? 4'd4 : 4'd0;
      tick();
      if (k == 10) begin
        n_checks++; if (hit2 !== 1'b0) begin n_errors++; $display("FAIL reattack_invuln_hit2: got %b expected 0", hit2); end
        n_checks++; if (health2 !== 7'd90) begin n_errors++; $display("FAIL reattack_invuln_health2: got %0d expected 90", health2); end
      end
      if (k == 35) begin
        n_checks++; if (hit2 !== 1'b1) begin n_errors++; $display("FAIL reattack_hit2: got %b expected 1", hit2); end
        n_checks++; if (health2 !== 7'd80) begin n_errors++; $display("FAIL reattack_health2: got %0d expected 80", health2); end
      end
    end
    p1_state = 4'd0;
    tick();
  endtask

  task automatic test_trade();
    apply_reset();
    p1_state = 4'd4; p2_state = 4'd4;
    tick();
    n_checks++; if ({hit1, hit2} !== 2'b11) begin n_errors++; $display("FAIL trade_hits: got %b expected 11", {hit1, hit2}); end
    n_checks++; if ({health1, health2} !== {7'd90, 7'd90}) begin n_errors++; $display("FAIL trade_health: got %0d/%0d expected 90/90", health1, health2); end
    tick();
    n_checks++; if ({hit1, hit2} !== 2'b00) begin n_errors++; $display("FAIL trade_pulse_end: got %b expected 00", {hit1, hit2}); end
    p1_state = 4'd0; p2_state = 4'd0;
    tick();
  endtask

  task automatic test_box_edges();
    apply_reset();
    p2_hurt_x1 = 10'd260;
    p1_state = 4'd4;
    tick();
    n_checks++; if (hit2 !== 1'b1) begin n_errors++; $display("FAIL edge_touch_hit2: got %b expected 1", hit2); end
    apply_reset();
    p2_hurt_x1 = 10'd261;
    p1_state = 4'd4;
    tick();
    n_checks++; if (hit2 !== 1'b0 || health2 !== 7'd100) begin n_errors++; $display("FAIL edge_gap: got hit2=%b health2=%0d expected 0/100", hit2, health2); end
    apply_reset();
    p1_hit_x1 = 10'd270;
    p1_state = 4'd4;
    tick();
    n_checks++; if (hit2 !== 1'b0 || health2 !== 7'd100) begin n_errors++; $display("FAIL edge_invalid_box: got hit2=%b health2=%0d expected 0/100", hit2, health2); end
    p1_state = 4'd0;
    tick();
  endtask

  task automatic test_double_ko();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      p1_state = 4'd4; p2_state = 4'd4;
      tick();
      p1_state = 4'd0; p2_state = 4'd0;
      ticks(31);
    end
    n_checks++; if ({health1, health2} !== {7'd10, 7'd10}) begin n_errors++; $display("FAIL ko_pre_health: got %0d/%0d expected 10/10", health1, health2); end
    n_checks++; if (game_over !== 1'b0) begin n_errors++; $display("FAIL ko_pre_game_over: got %b expected 0", game_over); end
    p1_state = 4'd4; p2_state = 4'd4;
    tick();
    n_checks++; if ({health1, health2} !== 14'd0) begin n_errors++; $display("FAIL ko_health: got %0d/%0d expected 0/0", health1, health2); end
    n_checks++; if (game_over !== 1'b1) begin n_errors++; $display("FAIL ko_game_over: got %b expected 1", game_over); end
    n_checks++; if (winner !== 2'b11) begin n_errors++; $display("FAIL ko_winner: got %b expected 11", winner); end
    p1_state = 4'd0; p2_state = 4'd0;
    ticks(31);
    p1_state = 4'd4; p2_state = 4'd4;
    tick();
    n_checks++; if ({hit1, hit2} !== 2'b00) begin n_errors++; $display("FAIL ko_frozen_hits: got %b expected 00", {hit1, hit2}); end
    n_checks++; if (winner !== 2'b11 || game_over !== 1'b1) begin n_errors++; $display("FAIL ko_frozen_state: got winner=%b game_over=%b expected 11/1", winner, game_over); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({health1, health2} !== {7'd100, 7'd100}) begin n_errors++; $display("FAIL ko_reset_health: got %0d/%0d expected 100/100", health1, health2); end
    n_checks++; if (winner !== 2'b00 || game_over !== 1'b0) begin n_errors++; $display("FAIL ko_reset_state: got winner=%b game_over=%b expected 00/0", winner, game_over); end
    p1_state = 4'd0; p2_state = 4'd0;
    tick();
  endtask

  task automatic test_single_ko();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      p1_state = 4'd4;
      tick();
      p1_state = 4'd0;
      ticks(31);
    end
    n_checks++; if ({health1, health2} !== {7'd100, 7'd0}) begin n_errors++; $display("FAIL p1_win_health: got %0d/%0d expected 100/0", health1, health2); end
    n_checks++; if (winner !== 2'b01 || game_over !== 1'b1) begin n_errors++; $display("FAIL p1_win_state: got winner=%b game_over=%b expected 01/1", winner, game_over); end
  endtask

  task automatic test_reset_priority();
    apply_reset();
    p1_state = 4'd4; p2_state = 4'd4;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({health1, health2} !== {7'd100, 7'd100}) begin n_errors++; $display("FAIL rstprio_health: got %0d/%0d expected 100/100", health1, health2); end
    n_checks++; if ({hit1, hit2} !== 2'b00) begin n_errors++; $display("FAIL rstprio_hits: got %b expected 00", {hit1, hit2}); end
    tick();
    n_checks++; if ({hit1, hit2} !== 2'b11 || health2 !== 7'd90) begin n_errors++; $display("FAIL rstprio_after: got hits=%b health2=%0d expected 11/90", {hit1, hit2}, health2); end
    p1_state = 4'd0; p2_state = 4'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_reattack();
    test_trade();
    test_box_edges();
    test_double_ko();
    test_single_ko();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
